vga_sync: RTL and testbench

Pixel-timing generator that drives the shared `x`/`y` raster interface consumed by the game renderers (maze, sprites, RGB mux). It divides the system clock down to the pixel rate and runs horizontal and vertical counters. From those counters it produces the coordinates, the sync pulses, the video-active flag and the per-frame strobes for one 640x480@60 VGA frame. All timing is parameterised. The default parameters give an 800x525 total raster.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_sync_if.sv | 24 ++
 rtl/pix_div.sv | 30 +++
 rtl/vga_sync.sv | 100 ++++++++++
 tb/tb_vga_sync.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing constants and helpers for the VGA sync generator and the
// renderers that consume its x/y coordinates.
package vga_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned MAX_TOTAL = 1 << COORD_W;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam bit          DEF_SYNC_POL = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // True when v lies in [lo, lo+len-1].
    function automatic logic in_window(input coord_t v, input int unsigned lo,
                                       input int unsigned len);
        return (32'(v) >= lo) && (32'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Raster interface between the sync generator (master) and the renderers (slave).
interface vga_sync_if;
    import vga_pkg::*;

    logic   en;
    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   pixel_tick;
    logic   frame_tick;

    modport master (
        input  en,
        output x, y, hsync, vsync, video_on, pixel_tick, frame_tick
    );

    modport slave (
        output en,
        input  x, y, hsync, vsync, video_on, pixel_tick, frame_tick
    );

endinterface

// File: rtl/pix_div.sv
// Clock-enable divider: div counts 0..CLK_DIV-1 while enabled, pixel_tick marks
// the last system clock of each pixel period.
module pix_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic pixel_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             last;

    assign last = (div == DIV_W'(CLK_DIV - 1));

    // Gated by reset so no tick is seen while the block is held in reset.
    assign pixel_tick = en & reset & last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else if (en) begin
            div <= last ? '0 : div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA pixel-timing generator: x/y raster counters, sync decode and per-frame strobes,
// with sync/video_on registered from next-state coordinates for zero skew to x/y.
module vga_sync
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        reset,
    vga_sync_if.master  bus
);

    localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_sync: raster total exceeds coordinate range");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync: CLK_DIV out of range 1..16");
    end

    logic   tick;
    coord_t x_q;
    coord_t y_q;
    coord_t x_nxt;
    coord_t y_nxt;
    logic   x_last;
    logic   y_last;
    sync_t  sync_q;
    sync_t  sync_nxt;

    pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk        (clk),
        .reset      (reset),
        .en         (bus.en),
        .pixel_tick (tick)
    );

    assign x_last = (x_q == COORD_W'(H_TOTAL - 1));
    assign y_last = (y_q == COORD_W'(V_TOTAL - 1));

    // Next raster position; y only moves when x wraps.
    always_comb begin
        x_nxt = x_q;
        y_nxt = y_q;
        if (tick) begin
            if (x_last) begin
                x_nxt = '0;
                y_nxt = y_last ? '0 : y_q + COORD_W'(1);
            end else begin
                x_nxt = x_q + COORD_W'(1);
            end
        end
    end

    // Decode from the next position so the registered flags line up with x/y.
    always_comb begin
        sync_nxt          = '0;
        sync_nxt.hsync    = in_window(x_nxt, HS_START, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        sync_nxt.vsync    = in_window(y_nxt, VS_START, V_SYNC) ? SYNC_POL : ~SYNC_POL;
        sync_nxt.video_on = (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q             <= '0;
            y_q             <= '0;
            sync_q.hsync    <= ~SYNC_POL;
            sync_q.vsync    <= ~SYNC_POL;
            sync_q.video_on <= 1'b1;
        end else begin
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            sync_q <= sync_nxt;
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.hsync      = sync_q.hsync;
    assign bus.vsync      = sync_q.vsync;
    assign bus.video_on   = sync_q.video_on;
    assign bus.pixel_tick = tick;
    assign bus.frame_tick = tick & x_last & y_last;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: two small-raster instances (CLK_DIV=2 active-low sync, CLK_DIV=1
// active-high sync) checked every cycle against a linear pixel-index model.
module tb_vga_sync;

    localparam int A_DIV = 2, A_HA = 16, A_HFP = 2, A_HS = 3, A_HBP = 4;
    localparam int A_VA = 8, A_VFP = 2, A_VS = 2, A_VBP = 3;
    localparam bit A_POL = 1'b0;
    localparam int B_DIV = 1, B_HA = 10, B_HFP = 1, B_HS = 2, B_HBP = 2;
    localparam int B_VA = 6, B_VFP = 1, B_VS = 1, B_VBP = 2;
    localparam bit B_POL = 1'b1;

    int cd[2]  = '{A_DIV, B_DIV};
    int ha[2]  = '{A_HA, B_HA};
    int va[2]  = '{A_VA, B_VA};
    int ht[2]  = '{A_HA + A_HFP + A_HS + A_HBP, B_HA + B_HFP + B_HS + B_HBP};
    int vt[2]  = '{A_VA + A_VFP + A_VS + A_VBP, B_VA + B_VFP + B_VS + B_VBP};
    int hs0[2] = '{A_HA + A_HFP, B_HA + B_HFP};
    int hw[2]  = '{A_HS, B_HS};
    int vs0[2] = '{A_VA + A_VFP, B_VA + B_VFP};
    int vw[2]  = '{A_VS, B_VS};
    bit pol[2] = '{A_POL, B_POL};

    // Model state: clock phase inside the pixel and linear pixel index inside the frame.
    int ph[2];
    int n[2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b1;

    always #5 clk = ~clk;

    vga_sync_if bus_a ();
    vga_sync_if bus_b ();
    assign bus_a.en = en;
    assign bus_b.en = en;

    vga_sync #(
        .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP), .SYNC_POL(A_POL)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    vga_sync #(
        .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP), .SYNC_POL(B_POL)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                ph[i] <= 0;
                n[i]  <= 0;
            end else if (en) begin
                if (ph[i] == cd[i] - 1) begin
                    ph[i] <= 0;
                    n[i]  <= (n[i] + 1) % (ht[i] * vt[i]);
                end else begin
                    ph[i] <= ph[i] + 1;
                end
            end
        end
    end

    task automatic cmp(input string what, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", what, cyc, act, exp);
        end
    endtask

    task automatic check(input int i, input string nm, input int ax, input int ay,
                         input int ahs, input int avs, input int avo, input int apt,
                         input int aft);
        int ex, ey, ept, eft, ehs, evs, evo;
        if (!reset) begin
            ex = 0; ey = 0; ept = 0; eft = 0;
        end else begin
            ex  = n[i] % ht[i];
            ey  = n[i] / ht[i];
            ept = (en && ph[i] == cd[i] - 1) ? 1 : 0;
            eft = (ept == 1 && n[i] == ht[i] * vt[i] - 1) ? 1 : 0;
        end
        ehs = (ex >= hs0[i] && ex < hs0[i] + hw[i]) ? int'(pol[i]) : int'(!pol[i]);
        evs = (ey >= vs0[i] && ey < vs0[i] + vw[i]) ? int'(pol[i]) : int'(!pol[i]);
        evo = (ex < ha[i] && ey < va[i]) ? 1 : 0;
        cmp({nm, ".x"}, ax, ex);
        cmp({nm, ".y"}, ay, ey);
        cmp({nm, ".hsync"}, ahs, ehs);
        cmp({nm, ".vsync"}, avs, evs);
        cmp({nm, ".video_on"}, avo, evo);
        cmp({nm, ".pixel_tick"}, apt, ept);
        cmp({nm, ".frame_tick"}, aft, eft);
    endtask

    always @(negedge clk) begin
        check(0, "a", int'(bus_a.x), int'(bus_a.y), int'(bus_a.hsync), int'(bus_a.vsync),
              int'(bus_a.video_on), int'(bus_a.pixel_tick), int'(bus_a.frame_tick));
        check(1, "b", int'(bus_b.x), int'(bus_b.y), int'(bus_b.hsync), int'(bus_b.vsync),
              int'(bus_b.video_on), int'(bus_b.pixel_tick), int'(bus_b.frame_tick));
    end

    task automatic wait_xy_a(input int wx, input int wy, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (int'(bus_a.x) == wx && int'(bus_a.y) == wy) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: position (%0d,%0d) not reached within %0d cycles", tag, wx, wy, budget);
    endtask

    task automatic wait_ft(input int i, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if ((i == 0 ? bus_a.frame_tick : bus_b.frame_tick) == 1'b1) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: no frame_tick within %0d cycles", tag, budget);
    endtask

    initial begin
        int hs_a, vs_a, vo_a, ft_a, hs_b, vs_b, vo_b, ft_b;
        int t0, t1, cyc_r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst.a.hsync", int'(bus_a.hsync), 1);
        cmp("rst.a.vsync", int'(bus_a.vsync), 1);
        cmp("rst.b.hsync", int'(bus_b.hsync), 0);
        cmp("rst.a.video_on", int'(bus_a.video_on), 1);
        cmp("rst.b.pixel_tick", int'(bus_b.pixel_tick), 0);

        // Release: A ticks first in clock 2, B in clock 1.
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        cmp("first.a.tick_clk1", int'(bus_a.pixel_tick), 0);
        cmp("first.b.tick_clk1", int'(bus_b.pixel_tick), 1);
        @(negedge clk);
        cmp("first.a.tick_clk2", int'(bus_a.pixel_tick), 1);
        cmp("first.a.x_clk2", int'(bus_a.x), 0);
        @(negedge clk);
        cmp("first.a.x_clk3", int'(bus_a.x), 1);

        // One full frame of A (five of B) between consecutive A frame ticks.
        wait_ft(0, 2000, "frame.a.start");
        hs_a = 0; vs_a = 0; vo_a = 0; ft_a = 0;
        hs_b = 0; vs_b = 0; vo_b = 0; ft_b = 0;
        repeat (750) begin
            @(negedge clk);
            if (bus_a.hsync == A_POL) hs_a++;
            if (bus_a.vsync == A_POL) vs_a++;
            if (bus_a.video_on) vo_a++;
            if (bus_a.frame_tick) ft_a++;
            if (bus_b.hsync == B_POL) hs_b++;
            if (bus_b.vsync == B_POL) vs_b++;
            if (bus_b.video_on) vo_b++;
            if (bus_b.frame_tick) ft_b++;
        end
        cmp("frame.a.tick_at_750", int'(bus_a.frame_tick), 1);
        cmp("frame.a.ticks", ft_a, 1);
        cmp("frame.a.hsync_clks", hs_a, 90);
        cmp("frame.a.vsync_clks", vs_a, 100);
        cmp("frame.a.video_clks", vo_a, 256);
        cmp("frame.b.ticks", ft_b, 5);
        cmp("frame.b.hsync_clks", hs_b, 100);
        cmp("frame.b.vsync_clks", vs_b, 75);
        cmp("frame.b.video_clks", vo_b, 300);

        // 37-clock enable pause mid-line stretches that line to 50+37 clocks.
        wait_xy_a(0, 5, 2000, "pause.start");
        t0 = cyc;
        wait_xy_a(12, 5, 200, "pause.at12");
        @(posedge clk); #1 en = 1'b0;
        @(negedge clk);
        cmp("pause.x_held", int'(bus_a.x), 12);
        cmp("pause.a.tick_low", int'(bus_a.pixel_tick), 0);
        cmp("pause.b.tick_low", int'(bus_b.pixel_tick), 0);
        repeat (37) @(posedge clk);
        #1 en = 1'b1;
        wait_xy_a(0, 6, 300, "pause.end");
        t1 = cyc;
        cmp("pause.line_clks", t1 - t0, 87);

        // Reset with both syncs active drops them asynchronously.
        wait_xy_a(19, 10, 2000, "midrst.pos");
        cmp("midrst.pre_hsync", int'(bus_a.hsync), 0);
        cmp("midrst.pre_vsync", int'(bus_a.vsync), 0);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        cmp("midrst.hsync", int'(bus_a.hsync), 1);
        cmp("midrst.vsync", int'(bus_a.vsync), 1);
        cmp("midrst.x", int'(bus_a.x), 0);
        cmp("midrst.y", int'(bus_a.y), 0);
        cmp("midrst.b.hsync", int'(bus_b.hsync), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cyc_r = cyc;
        wait_ft(1, 400, "midrst.b.frame");
        cmp("midrst.b.first_frame_clk", cyc - cyc_r + 1, 150);
        wait_ft(0, 1000, "midrst.a.frame");
        cmp("midrst.a.first_frame_clk", cyc - cyc_r + 1, 750);

        // Random enable gaps and occasional mid-cycle resets.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 599) == 0) begin
                #1 reset = 1'b0;
                @(posedge clk); #3 reset = 1'b1;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
